// File: rtl/kc705_sw_debounce.sv
// kc705_sw_debounce: conditions raw DIP-switch / pushbutton pins into clean
// debounced levels plus one-cycle rise/fall events, all in clk_100m.
// Each channel is a SYNC_STAGES-deep synchronizer followed by a two-state
// debounce FSM with a CNT_W-bit stability counter.
// Optional long-press detection is compiled in with KC705_SW_LONGPRESS_EN;
// without it sw_long is tied low and LONG_W has no effect.
//
// Debounce FSM states:
//   state     | meaning
//   ST_STABLE | sync agrees with sw_level, counter held at 0
//   ST_VERIFY | sync differs from sw_level, counting toward all-ones
module kc705_sw_debounce #(
  parameter int              N_CH        = 5,
  parameter int              CNT_W       = 20,
  parameter int              SYNC_STAGES = 2,
  parameter logic [N_CH-1:0] RST_VAL     = {N_CH{1'b0}},
  parameter int              LONG_W      = 28
) (
  input  logic            clk_100m,
  input  logic            rst,
  input  logic [N_CH-1:0] sw_in,
  output logic [N_CH-1:0] sw_level,
  output logic [N_CH-1:0] sw_rise,
  output logic [N_CH-1:0] sw_fall,
  output logic            sw_changed,
  output logic [N_CH-1:0] sw_long
);

  typedef enum logic {
    ST_STABLE = 1'b0,
    ST_VERIFY = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Parameter sanity: a single flop is not a safe synchronizer.
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("kc705_sw_debounce: SYNC_STAGES must be at least 2");
  end
  if (LONG_W < 1) begin : g_bad_long
    $error("kc705_sw_debounce: LONG_W must be at least 1");
  end

  logic [N_CH-1:0] r_sync [SYNC_STAGES];
  logic [N_CH-1:0] w_sync;
  logic [N_CH-1:0] w_level;
  logic [N_CH-1:0] w_rise;
  logic [N_CH-1:0] w_fall;
  logic [N_CH-1:0] w_long;

  // Plain flop chain; nothing may sit between stages.
  always_ff @(posedge clk_100m or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        r_sync[s] <= RST_VAL;
      end
    end else begin
      r_sync[0] <= sw_in;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        r_sync[s] <= r_sync[s-1];
      end
    end
  end

  assign w_sync = r_sync[SYNC_STAGES-1];

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_level;
    logic             w_level_nxt;
    logic             r_rise;
    logic             w_rise_nxt;
    logic             r_fall;
    logic             w_fall_nxt;

    // Debounce state, counter, level and registered edge pulses.
    always_ff @(posedge clk_100m or posedge rst) begin
      if (rst) begin
        r_state <= ST_STABLE;
        r_cnt   <= '0;
        r_level <= RST_VAL[i];
        r_rise  <= 1'b0;
        r_fall  <= 1'b0;
      end else begin
        r_state <= w_state_nxt;
        r_cnt   <= w_cnt_nxt;
        r_level <= w_level_nxt;
        r_rise  <= w_rise_nxt;
        r_fall  <= w_fall_nxt;
      end
    end

    // Next-state logic; the counter is compared to all-ones before
    // incrementing so it can never wrap.
    always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_level_nxt = r_level;
      w_rise_nxt  = 1'b0;
      w_fall_nxt  = 1'b0;
      case (r_state)
        ST_STABLE: begin
          w_cnt_nxt = '0;
          if (w_sync[i] != r_level) begin
            w_state_nxt = ST_VERIFY;
          end
        end
        ST_VERIFY: begin
          if (w_sync[i] == r_level) begin
            w_state_nxt = ST_STABLE;
            w_cnt_nxt   = '0;
          end else if (r_cnt == CNT_MAX) begin
            w_level_nxt = w_sync[i];
            w_rise_nxt  = w_sync[i];
            w_fall_nxt  = ~w_sync[i];
            w_state_nxt = ST_STABLE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        default: begin
          w_state_nxt = ST_STABLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end

    assign w_level[i] = r_level;
    assign w_rise[i]  = r_rise;
    assign w_fall[i]  = r_fall;

`ifdef KC705_SW_LONGPRESS_EN
    logic [LONG_W-1:0] r_lcnt;
    logic              r_lfull;
    logic              r_long;

    // Hold-time counter; r_lfull remembers the counter was already
    // saturated so the pulse fires once, 2^LONG_W cycles after the rise.
    always_ff @(posedge clk_100m or posedge rst) begin
      if (rst) begin
        r_lcnt  <= '0;
        r_lfull <= 1'b0;
        r_long  <= 1'b0;
      end else if (!r_level) begin
        r_lcnt  <= '0;
        r_lfull <= 1'b0;
        r_long  <= 1'b0;
      end else begin
        if (r_lcnt != {LONG_W{1'b1}}) begin
          r_lcnt <= r_lcnt + LONG_W'(1);
        end
        r_lfull <= (r_lcnt == {LONG_W{1'b1}});
        r_long  <= (r_lcnt == {LONG_W{1'b1}}) && !r_lfull;
      end
    end

    assign w_long[i] = r_long;
`else
    assign w_long[i] = 1'b0;
`endif
  end

  assign sw_level   = w_level;
  assign sw_rise    = w_rise;
  assign sw_fall    = w_fall;
  assign sw_long    = w_long;
  assign sw_changed = |(w_rise | w_fall);

endmodule
